// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: zero/sign/upper/branch-offset modes with a
// registered valid/ready output stage, a one-entry skid buffer and a flush.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PAD_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_t;

  logic [OUT_W-1:0] ext_zero;
  logic [OUT_W-1:0] ext_sign;
  logic [OUT_W-1:0] ext_upper;
  logic [OUT_W-1:0] ext_branch;
  logic [OUT_W-1:0] ext_imm;

  logic             sk_valid;
  logic [OUT_W-1:0] sk_imm;
  logic [TAG_W-1:0] sk_tag;

  always_comb begin
    ext_zero   = {{PAD_W{1'b0}}, in_imm};
    ext_sign   = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
    ext_upper  = {in_imm, {PAD_W{1'b0}}};
    ext_branch = ext_sign << SHAMT;
    case (mode_t'(in_mode))
      MODE_ZERO:   ext_imm = ext_zero;
      MODE_SIGN:   ext_imm = ext_sign;
      MODE_UPPER:  ext_imm = ext_upper;
      default:     ext_imm = ext_branch;
    endcase
  end

  // The skid slot is the only thing that can block upstream, so in_ready is
  // simply its inverted valid flop and never sees out_ready combinationally.
  assign in_ready = ~sk_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_tag   <= '0;
      sk_valid  <= 1'b0;
      sk_imm    <= '0;
      sk_tag    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      sk_valid  <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // Output slot frees up: the older skid entry always goes first.
      if (sk_valid) begin
        out_valid <= 1'b1;
        out_imm   <= sk_imm;
        out_tag   <= sk_tag;
        sk_valid  <= 1'b0;
      end else if (in_valid) begin
        out_valid <= 1'b1;
        out_imm   <= ext_imm;
        out_tag   <= in_tag;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_valid && !sk_valid) begin
      sk_valid <= 1'b1;
      sk_imm   <= ext_imm;
      sk_tag   <= in_tag;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed mode/backpressure/flush/reset
// cases plus randomised traffic on a default and a narrow (12->24) instance.
module tb_imm_extend_pipe;

  typedef struct {
    longint imm;
    longint tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [15:0] in_imm_a;
  logic [1:0]  in_mode_a;
  logic [4:0]  in_tag_a, out_tag_a;
  logic [31:0] out_imm_a;

  logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [11:0] in_imm_b;
  logic [1:0]  in_mode_b;
  logic [4:0]  in_tag_b, out_tag_b;
  logic [23:0] out_imm_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   xfer_a = 0;
  int   xfer_b = 0;

  logic        stall_a = 1'b0, stall_b = 1'b0;
  logic [31:0] hold_imm_a;
  logic [23:0] hold_imm_b;
  logic [4:0]  hold_tag_a, hold_tag_b;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHAMT(2), .TAG_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_imm(in_imm_a),
    .in_mode(in_mode_a), .in_tag(in_tag_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_imm(out_imm_a), .out_tag(out_tag_a)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(24), .SHAMT(1), .TAG_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_imm(in_imm_b),
    .in_mode(in_mode_b), .in_tag(in_tag_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_imm(out_imm_b), .out_tag(out_tag_b)
  );

  always #5 clk = ~clk;

  // Reference: treat the immediate as an integer and apply the mode rule.
  function automatic longint model_ext(longint imm, int mode, int in_w, int out_w, int shamt);
    longint v;
    v = imm;
    if ((mode == 1 || mode == 3) && imm >= (longint'(2) ** (in_w - 1)))
      v = imm - longint'(2) ** in_w;
    if (mode == 2)
      v = imm * (longint'(2) ** (out_w - in_w));
    if (mode == 3)
      v = v * (longint'(2) ** shamt);
    return v & ((longint'(2) ** out_w) - 1);
  endfunction

  function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitors pop on every output transfer and check stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        checkOutput("stable_valid_a", out_valid_a, 1);
        checkOutput("stable_imm_a", out_imm_a, hold_imm_a);
        checkOutput("stable_tag_a", out_tag_a, hold_tag_a);
      end
      if (out_valid_a && out_ready_a) begin
        xfer_a++;
        if (q_a.size() == 0) checkOutput("unexpected_out_a", out_valid_a, 0);
        else begin
          e = q_a.pop_front();
          checkOutput("imm_a", out_imm_a, e.imm);
          checkOutput("tag_a", out_tag_a, e.tag);
        end
      end
      stall_a = out_valid_a && !out_ready_a && !flush_a;
      hold_imm_a = out_imm_a;
      hold_tag_a = out_tag_a;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_b = 1'b0;
    end else begin
      if (stall_b) begin
        checkOutput("stable_valid_b", out_valid_b, 1);
        checkOutput("stable_imm_b", out_imm_b, hold_imm_b);
        checkOutput("stable_tag_b", out_tag_b, hold_tag_b);
      end
      if (out_valid_b && out_ready_b) begin
        xfer_b++;
        if (q_b.size() == 0) checkOutput("unexpected_out_b", out_valid_b, 0);
        else begin
          e = q_b.pop_front();
          checkOutput("imm_b", out_imm_b, e.imm);
          checkOutput("tag_b", out_tag_b, e.tag);
        end
      end
      stall_b = out_valid_b && !out_ready_b && !flush_b;
      hold_imm_b = out_imm_b;
      hold_tag_b = out_tag_b;
    end
  end

  // Push expectations after the monitors have popped for this cycle.
  task automatic recordA();
    if (flush_a) q_a.delete();
    else if (in_valid_a && in_ready_a)
      q_a.push_back('{model_ext(longint'(in_imm_a), int'(in_mode_a), 16, 32, 2), longint'(in_tag_a)});
  endtask

  task automatic recordB();
    if (flush_b) q_b.delete();
    else if (in_valid_b && in_ready_b)
      q_b.push_back('{model_ext(longint'(in_imm_b), int'(in_mode_b), 12, 24, 1), longint'(in_tag_b)});
  endtask

  // One cycle on instance A; entered and left just after a rising edge.
  task automatic applyStimulus(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                               input logic [4:0] tag, input logic rdy, input logic fl);
    in_valid_a = v;
    in_imm_a = imm;
    in_mode_a = mode;
    in_tag_a = tag;
    out_ready_a = rdy;
    flush_a = fl;
    @(negedge clk);
    #1;
    recordA();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] sweep_imm[8];
  logic [1:0]  sweep_mode[8];
  logic [31:0] sweep_exp[8];

  initial begin
    int next_tag;
    sweep_imm  = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'hFFFF, 16'h7FFF, 16'h1234, 16'h0000};
    sweep_mode = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2, 2'd3};
    sweep_exp  = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004,
                   32'hFFFFFFFC, 32'h00007FFF, 32'h12340000, 32'h00000000};

    rst_n = 1'b0;
    flush_a = 0; in_valid_a = 0; in_imm_a = '0; in_mode_a = '0; in_tag_a = '0; out_ready_a = 1;
    flush_b = 0; in_valid_b = 0; in_imm_b = '0; in_mode_b = '0; in_tag_b = '0; out_ready_b = 1;
    #3;
    checkOutput("reset_out_valid", out_valid_a, 0);
    checkOutput("reset_in_ready", in_ready_a, 1);
    checkOutput("reset_out_imm", out_imm_a, 0);
    checkOutput("reset_out_tag", out_tag_a, 0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] mode sweep and boundary values");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, sweep_imm[i], sweep_mode[i], 5'(i + 1), 1, 0);
      checkOutput("latency_valid", out_valid_a, 1);
      checkOutput("sweep_imm", out_imm_a, sweep_exp[i]);
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("sweep_drained", out_valid_a, 0);

    $display("[TB] backpressure stream");
    next_tag = 1;
    for (int c = 0; c < 30 && next_tag <= 6; c++) begin
      if (c == 3) checkOutput("bp_in_ready_low", in_ready_a, 0);
      if (c == 2) checkOutput("bp_in_ready_high", in_ready_a, 1);
      in_valid_a = 1;
      in_imm_a = 16'(next_tag * 16'h1111);
      in_mode_a = 2'd1;
      in_tag_a = 5'(next_tag);
      out_ready_a = !(c >= 2 && c < 5);
      flush_a = 0;
      @(negedge clk);
      #1;
      if (in_ready_a) next_tag++;
      recordA();
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("bp_all_delivered", q_a.size(), 0);

    $display("[TB] flush while full");
    applyStimulus(1, 16'h0101, 2'd1, 5'd10, 0, 0);
    applyStimulus(1, 16'h0202, 2'd1, 5'd11, 0, 0);
    checkOutput("flush_full", in_ready_a, 0);
    applyStimulus(1, 16'h0303, 2'd1, 5'd12, 0, 1);
    checkOutput("flush_out_valid", out_valid_a, 0);
    checkOutput("flush_in_ready", in_ready_a, 1);
    applyStimulus(1, 16'h00AB, 2'd0, 5'd13, 1, 0);
    checkOutput("post_flush_valid", out_valid_a, 1);
    checkOutput("post_flush_tag", out_tag_a, 13);
    checkOutput("post_flush_imm", out_imm_a, 32'h000000AB);
    applyStimulus(0, 0, 0, 0, 1, 0);

    $display("[TB] asynchronous reset while full");
    applyStimulus(1, 16'h4444, 2'd2, 5'd20, 0, 0);
    applyStimulus(1, 16'h5555, 2'd2, 5'd21, 0, 0);
    in_valid_a = 0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", out_valid_a, 0);
    checkOutput("async_in_ready", in_ready_a, 1);
    checkOutput("async_out_imm", out_imm_a, 0);
    checkOutput("async_out_tag", out_tag_a, 0);
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] randomised traffic on both instances");
    xfer_a = 0;
    xfer_b = 0;
    for (int c = 0; c < 50000 && (xfer_a < 10000 || xfer_b < 4000); c++) begin
      in_valid_a = 1'($urandom_range(0, 1));
      in_imm_a = 16'($urandom);
      in_mode_a = 2'($urandom);
      in_tag_a = 5'($urandom);
      out_ready_a = 1'($urandom_range(0, 1));
      flush_a = ($urandom_range(0, 63) == 0);
      in_valid_b = 1'($urandom_range(0, 1));
      in_imm_b = 12'($urandom);
      in_mode_b = 2'($urandom);
      in_tag_b = 5'($urandom);
      out_ready_b = 1'($urandom_range(0, 1));
      flush_b = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      #1;
      recordA();
      recordB();
      @(posedge clk);
      #1;
    end
    if (xfer_a < 10000) checkOutput("random_budget_a", xfer_a, 10000);
    if (xfer_b < 4000) checkOutput("random_budget_b", xfer_b, 4000);

    in_valid_a = 0; flush_a = 0; out_ready_a = 1;
    in_valid_b = 0; flush_b = 0; out_ready_b = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      @(posedge clk);
      #1;
    end
    checkOutput("drain_a", q_a.size(), 0);
    checkOutput("drain_b", q_b.size(), 0);
    checkOutput("idle_a", out_valid_a, 0);
    checkOutput("idle_b", out_valid_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
